// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every N_IN-bit vector, samples X after SETTLE cycles, scores against EXPECTED.
// Optional first-fail capture ports are built when TT_FIRST_FAIL_EN is defined.
module truth_table_sweeper #(
    parameter int                   N_IN     = 3,
    parameter int                   SETTLE   = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'hFA
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   X,
    output logic [N_IN-1:0]        VEC,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [(1<<N_IN)-1:0]   TABLE,
    output logic                   PASS,
`ifdef TT_FIRST_FAIL_EN
    output logic                   FAIL_VALID,
    output logic [N_IN-1:0]        FAIL_IDX,
`endif
    output logic [N_IN:0]          MISMATCH
);

    // state | meaning
    // IDLE   | waiting for START, results held
    // HOLD   | driving VEC, counting settle cycles, sampling X on the last one
    // FINISH | one-cycle DONE, PASS already registered
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int                 ROWS    = 1 << N_IN;
    localparam int                 CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]    VEC_MAX = '1;
    localparam logic [N_IN:0]      MIS_ONE = (N_IN+1)'(1);

    state_t                state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [N_IN-1:0]       vec_q,    vec_d;
    logic [ROWS-1:0]       table_q,  table_d;
    logic [N_IN:0]         mism_q,   mism_d;
    logic                  pass_q,   pass_d;
`ifdef TT_FIRST_FAIL_EN
    logic                  fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]       fail_idx_q,   fail_idx_d;
`endif

    logic sample_now;
    logic last_row;

    assign sample_now = (state_q == HOLD) && (cnt_q == CNT_MAX);
    assign last_row   = (vec_q == VEC_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            table_q <= '0;
            mism_q  <= '0;
            pass_q  <= 1'b0;
`ifdef TT_FIRST_FAIL_EN
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            table_q <= table_d;
            mism_q  <= mism_d;
            pass_q  <= pass_d;
`ifdef TT_FIRST_FAIL_EN
            fail_valid_q <= fail_valid_d;
            fail_idx_q   <= fail_idx_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = HOLD;
            HOLD:    if (sample_now && last_row) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; PASS is scored from the table including the final sample.
    always_comb begin
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        table_d = table_q;
        mism_d  = mism_q;
        pass_d  = pass_q;
`ifdef TT_FIRST_FAIL_EN
        fail_valid_d = fail_valid_q;
        fail_idx_d   = fail_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    cnt_d   = '0;
                    vec_d   = '0;
                    table_d = '0;
                    mism_d  = '0;
                    pass_d  = 1'b0;
`ifdef TT_FIRST_FAIL_EN
                    fail_valid_d = 1'b0;
                    fail_idx_d   = '0;
`endif
                end
            end
            HOLD: begin
                if (sample_now) begin
                    table_d[vec_q] = X;
                    if (X != EXPECTED[vec_q]) begin
                        mism_d = mism_q + MIS_ONE;
`ifdef TT_FIRST_FAIL_EN
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_idx_d   = vec_q;
                        end
`endif
                    end
                    if (last_row) begin
                        pass_d = (table_d == EXPECTED);
                    end else begin
                        vec_d = vec_q + 1'b1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: vec_d = '0;
            default: begin
                cnt_d = '0;
                vec_d = '0;
            end
        endcase
    end

    always_comb begin
        BUSY     = (state_q == HOLD);
        DONE     = (state_q == FINISH);
        VEC      = vec_q;
        TABLE    = table_q;
        PASS     = pass_q;
        MISMATCH = mism_q;
`ifdef TT_FIRST_FAIL_EN
        FAIL_VALID = fail_valid_q;
        FAIL_IDX   = fail_idx_q;
`endif
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table-driven sweeps plus hand-written multi-cycle corner cases.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       x;
    logic [2:0] vec;
    logic       busy, done, pass;
    logic [7:0] table_o;
    logic [3:0] mism;
`ifdef TT_FIRST_FAIL_EN
    logic       fail_valid;
    logic [2:0] fail_idx;
`endif

    logic       start1, x1;
    logic [2:0] vec1;
    logic       busy1, done1, pass1;
    logic [7:0] table1;
    logic [3:0] mism1;
`ifdef TT_FIRST_FAIL_EN
    logic       fail_valid1;
    logic [2:0] fail_idx1;
`endif

    int x_mode;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Network under test: A|C, optionally stuck at 0 or with row 3 broken.
    always_comb begin
        x = vec[2] | vec[0];
        if (x_mode == 1) x = 1'b0;
        else if (x_mode == 2 && vec == 3'd3) x = 1'b0;
    end
    assign x1 = vec1[2] | vec1[0];

    truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hFA)) dut (
        .CLK(clk), .RST(rst), .START(start), .X(x), .VEC(vec), .BUSY(busy), .DONE(done),
        .TABLE(table_o), .PASS(pass),
`ifdef TT_FIRST_FAIL_EN
        .FAIL_VALID(fail_valid), .FAIL_IDX(fail_idx),
`endif
        .MISMATCH(mism)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hFA)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .X(x1), .VEC(vec1), .BUSY(busy1), .DONE(done1),
        .TABLE(table1), .PASS(pass1),
`ifdef TT_FIRST_FAIL_EN
        .FAIL_VALID(fail_valid1), .FAIL_IDX(fail_idx1),
`endif
        .MISMATCH(mism1)
    );

    typedef struct {
        int         mode;
        logic [7:0] exp_table;
        logic [3:0] exp_mism;
        logic       exp_pass;
        logic       exp_fvalid;
        logic [2:0] exp_fidx;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse START for one edge; returns negedges until DONE (-1 on timeout) and BUSY cycle count.
    task automatic run_sweep(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, bcnt, ndone, pulse_k, dk[$];
        bit pulsed, seen5;

        vecs[0] = '{0, 8'hFA, 4'd0, 1'b1, 1'b0, 3'd0};
        vecs[1] = '{1, 8'h00, 4'd6, 1'b0, 1'b1, 3'd1};
        vecs[2] = '{2, 8'hF2, 4'd1, 1'b0, 1'b1, 3'd3};

        x_mode = 0;
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_vec",   32'(vec), 0);
        chk("reset_busy",  32'(busy), 0);
        chk("reset_done",  32'(done), 0);
        chk("reset_table", 32'(table_o), 0);
        chk("reset_pass",  32'(pass), 0);
        chk("reset_mism",  32'(mism), 0);
`ifdef TT_FIRST_FAIL_EN
        chk("reset_fvalid", 32'(fail_valid), 0);
        chk("reset_fidx",   32'(fail_idx), 0);
`endif

        foreach (vecs[i]) begin
            x_mode = vecs[i].mode;
            run_sweep(lat, bcnt);
            chk($sformatf("v%0d_done_latency", i), 32'(lat), 17);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 16);
            chk($sformatf("v%0d_table", i), 32'(table_o), 32'(vecs[i].exp_table));
            chk($sformatf("v%0d_mismatch", i), 32'(mism), 32'(vecs[i].exp_mism));
            chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
            chk($sformatf("v%0d_vec_last", i), 32'(vec), 7);
`ifdef TT_FIRST_FAIL_EN
            chk($sformatf("v%0d_fvalid", i), 32'(fail_valid), 32'(vecs[i].exp_fvalid));
            if (vecs[i].exp_fvalid)
                chk($sformatf("v%0d_fidx", i), 32'(fail_idx), 32'(vecs[i].exp_fidx));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 0);
            chk($sformatf("v%0d_vec_idle", i), 32'(vec), 0);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_table_hold", i), 32'(table_o), 32'(vecs[i].exp_table));
            chk($sformatf("v%0d_mism_hold", i), 32'(mism), 32'(vecs[i].exp_mism));
        end

        // START re-pulsed mid-sweep at VEC=4 must be ignored.
        x_mode = 0;
        lat = -1; ndone = 0; pulsed = 0; pulse_k = 0;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (pulsed && k == pulse_k + 1) start = 1'b0;
            if (!pulsed && busy && vec == 3'd4) begin
                start = 1'b1;
                pulsed = 1;
                pulse_k = k;
            end
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    chk("repulse_table", 32'(table_o), 32'hFA);
                    chk("repulse_pass", 32'(pass), 1);
                end
            end
        end
        start = 1'b0;
        chk("repulse_pulsed", 32'(pulsed), 1);
        chk("repulse_latency", 32'(lat), 17);
        chk("repulse_done_count", 32'(ndone), 1);

        // Synchronous reset mid-sweep at VEC=5.
        seen5 = 0;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy && vec == 3'd5) begin
                seen5 = 1;
                break;
            end
        end
        chk("midrst_reached_vec5", 32'(seen5), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_vec",   32'(vec), 0);
        chk("midrst_busy",  32'(busy), 0);
        chk("midrst_table", 32'(table_o), 0);
        chk("midrst_mism",  32'(mism), 0);
        chk("midrst_done",  32'(done), 0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 0);
        run_sweep(lat, bcnt);
        chk("postrst_latency", 32'(lat), 17);
        chk("postrst_table", 32'(table_o), 32'hFA);
        chk("postrst_pass", 32'(pass), 1);

        // SETTLE=1 with START held high: DONE every 10 cycles, first at 9.
        start1 = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (done1) begin
                dk.push_back(k);
                chk($sformatf("s1_pass_%0d", dk.size()), 32'(pass1), 1);
                chk($sformatf("s1_table_%0d", dk.size()), 32'(table1), 32'hFA);
            end
        end
        start1 = 1'b0;
        chk("s1_done_count", 32'(dk.size()), 4);
        if (dk.size() >= 4) begin
            chk("s1_first_done", 32'(dk[0]), 9);
            chk("s1_period_1", 32'(dk[1] - dk[0]), 10);
            chk("s1_period_2", 32'(dk[2] - dk[1]), 10);
            chk("s1_period_3", 32'(dk[3] - dk[2]), 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
